// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter: N-channel packet-locking arbiter with ready/valid handshakes.
// A winner is registered in IDLE (round-robin from ptr, or lowest index), then the
// grant is held in LOCKED until the granted channel's last beat is accepted.
// Ports:
//   clock, reset         - clock and asynchronous active-low reset
//   io_in_valid/last     - per-channel beat valid and last-beat flag
//   io_in_ready          - per-channel ready, only the granted bit can be set
//   io_out_valid/last    - forwarded beat valid and last flag
//   io_out_ready         - sink ready
//   io_out_chosen        - index of the granted channel (holds last grant in IDLE)
//   io_busy              - high while a grant is held
module packet_rr_arbiter #(
  parameter int unsigned N           = 10,
  parameter bit          ROUND_ROBIN = 1'b1,
  localparam int unsigned CW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  io_in_valid,
  input  logic [N-1:0]  io_in_last,
  output logic [N-1:0]  io_in_ready,
  output logic          io_out_valid,
  output logic          io_out_last,
  input  logic          io_out_ready,
  output logic [CW-1:0] io_out_chosen,
  output logic          io_busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] sel_q, sel_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_oh;
  logic          handshake;

  // First set request scanning start, start+1, ..., wrapping at N.
  function automatic logic [CW-1:0] pick(input logic [N-1:0] v, input logic [CW-1:0] start);
    logic [CW-1:0] res;
    logic          found;
    logic [N-1:0]  sh;
    int unsigned   idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(start) + i;
      if (idx >= N) idx = idx - N;
      sh = v >> idx;
      if (!found && sh[0]) begin
        res   = CW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // State, grant and rotation pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_oh = N'(1) << sel_q;

  // Next-state logic and the LOCKED datapath mux.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    io_in_ready   = '0;
    io_out_valid  = 1'b0;
    io_out_last   = 1'b0;
    io_busy       = 1'b0;
    handshake     = 1'b0;
    io_out_chosen = sel_q;
    case (state_q)
      IDLE: begin
        if (|io_in_valid) begin
          sel_d   = pick(io_in_valid, ROUND_ROBIN ? ptr_q : '0);
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        io_busy      = 1'b1;
        io_out_valid = |(io_in_valid & grant_oh);
        io_out_last  = |(io_in_valid & io_in_last & grant_oh);
        io_in_ready  = io_out_ready ? grant_oh : '0;
        handshake    = io_out_valid & io_out_ready;
        if (handshake && io_out_last) begin
          state_d = IDLE;
          // Rotate priority to the channel after the one just served.
          if (ROUND_ROBIN) ptr_d = (sel_q == CW'(N - 1)) ? '0 : sel_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Bench for packet_rr_arbiter: a round-robin and a fixed-priority instance (N=4)
// share stimulus; each is compared every cycle against a packet-level model.
module tb_packet_rr_arbiter;
  localparam int NCH = 4;

  logic           clock, reset;
  logic [NCH-1:0] vld, lst;
  logic           rdy;

  logic [NCH-1:0] rr_ready, fp_ready;
  logic           rr_ov, rr_ol, rr_busy, fp_ov, fp_ol, fp_busy;
  logic [1:0]     rr_chosen, fp_chosen;

  int total = 0;
  int bad   = 0;

  // model state per instance: index 0 = round robin, 1 = fixed priority
  int m_locked [2];
  int m_sel    [2];
  int m_ptr    [2];

  bit capture_en = 0;
  int seq[$];

  packet_rr_arbiter #(.N(NCH), .ROUND_ROBIN(1'b1)) u_rr (
    .clock(clock), .reset(reset), .io_in_valid(vld), .io_in_last(lst),
    .io_in_ready(rr_ready), .io_out_valid(rr_ov), .io_out_last(rr_ol),
    .io_out_ready(rdy), .io_out_chosen(rr_chosen), .io_busy(rr_busy));

  packet_rr_arbiter #(.N(NCH), .ROUND_ROBIN(1'b0)) u_fp (
    .clock(clock), .reset(reset), .io_in_valid(vld), .io_in_last(lst),
    .io_in_ready(fp_ready), .io_out_valid(fp_ov), .io_out_last(fp_ol),
    .io_out_ready(rdy), .io_out_chosen(fp_chosen), .io_busy(fp_busy));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int winner(input int md, input logic [NCH-1:0] v);
    int start = (md == 0) ? m_ptr[md] : 0;
    for (int k = 0; k < NCH; k++) begin
      int idx = (start + k) % NCH;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      m_locked[md] = 0; m_sel[md] = 0; m_ptr[md] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    for (int md = 0; md < 2; md++) begin
      if (m_locked[md] == 0) begin
        if (vld != 0) begin
          m_sel[md]    = winner(md, vld);
          m_locked[md] = 1;
        end
      end else if (vld[m_sel[md]] && rdy && lst[m_sel[md]]) begin
        m_locked[md] = 0;
        if (md == 0) m_ptr[md] = (m_sel[md] + 1) % NCH;
      end
    end
  endtask

  task automatic check_dut(input int md, input logic [NCH-1:0] r, input logic ov,
                           input logic ol, input logic [1:0] ch, input logic b);
    string p = (md == 0) ? "rr" : "fp";
    int ev = 0, el = 0, er = 0, eb = 0;
    if (m_locked[md] != 0) begin
      eb = 1;
      ev = vld[m_sel[md]];
      el = vld[m_sel[md]] & lst[m_sel[md]];
      er = rdy ? (1 << m_sel[md]) : 0;
    end
    chk({p, "_ready"}, r, er);
    chk({p, "_out_valid"}, ov, ev);
    chk({p, "_out_last"}, ol, el);
    chk({p, "_chosen"}, ch, m_sel[md]);
    chk({p, "_busy"}, b, eb);
  endtask

  task automatic check_all();
    check_dut(0, rr_ready, rr_ov, rr_ol, rr_chosen, rr_busy);
    check_dut(1, fp_ready, fp_ov, fp_ol, fp_chosen, fp_busy);
    if (capture_en && rr_busy) seq.push_back(int'(rr_chosen));
  endtask

  // One cycle: drive just after a rising edge, check on the falling edge.
  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] l, input logic r);
    vld = v; lst = l; rdy = r;
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; vld = '0; lst = '0; rdy = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    clock = 1'b0;
    do_reset();

    // round-robin fairness, every beat a single-beat packet
    capture_en = 1;
    for (int c = 0; c < 12; c++) cycle(4'b1111, 4'b1111, 1'b1);
    capture_en = 0;
    chk("rr_seq_len", seq.size(), 6);
    begin
      int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6 && i < seq.size(); i++) chk($sformatf("rr_seq%0d", i), seq[i], exp_seq[i]);
    end
    // fixed priority moves to ch1 once ch0 drops
    for (int c = 0; c < 6; c++) cycle(4'b1110, 4'b1110, 1'b1);
    for (int c = 0; c < 2; c++) cycle(4'b0000, 4'b0000, 1'b1);

    // 3-beat packet on ch2
    do_reset();
    for (int c = 0; c < 5; c++)
      cycle((c <= 3) ? 4'b0100 : 4'b0000, (c == 3) ? 4'b0100 : 4'b0000, 1'b1);
    chk("ptr_after_ch2", int'(u_rr.ptr_q), 3);
    chk("fp_ptr_held", int'(u_fp.ptr_q), 0);

    // wrap-around: ptr=3, requests on ch0 and ch1
    cycle(4'b0011, 4'b0011, 1'b1);
    cycle(4'b0011, 4'b0011, 1'b1);
    chk("ptr_after_wrap", int'(u_rr.ptr_q), 1);
    cycle(4'b0011, 4'b0011, 1'b1);
    cycle(4'b0011, 4'b0011, 1'b1);
    chk("wrap_second_grant", int'(rr_chosen), 1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // backpressure: ch1 2-beat packet stalled while ch0 requests
    do_reset();
    cycle(4'b0010, 4'b0000, 1'b1);
    for (int c = 0; c < 3; c++) cycle(4'b0011, 4'b0000, 1'b0);
    cycle(4'b0011, 4'b0000, 1'b1);
    cycle(4'b0011, 4'b0010, 1'b1);
    chk("ptr_after_bp", int'(u_rr.ptr_q), 2);
    cycle(4'b0001, 4'b0001, 1'b1);
    cycle(4'b0001, 4'b0001, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // asynchronous reset in the middle of a ch2 packet
    do_reset();
    cycle(4'b0100, 4'b0000, 1'b1);
    vld = 4'b0100; lst = 4'b0000; rdy = 1'b1;
    @(negedge clock);
    check_all();
    chk("mid_busy_before", rr_busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", rr_busy, 0);
    chk("mid_rst_valid", rr_ov, 0);
    chk("mid_rst_ready", rr_ready, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) cycle(4'b1111, 4'b1111, 1'b1);

    // randomized traffic
    for (int c = 0; c < 800; c++)
      cycle(NCH'($urandom), NCH'($urandom), ($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
